// File: rtl/vram_fetcher.sv
// vram_fetcher: bank-1 VRAM read initiator fetching bitmap + attribute per cell.
// Optional VRAM_FETCH_ATTR_CACHE_EN skips the attribute read on a repeat address.
module vram_fetcher #(
    parameter int ACCESS_CYCLES = 6,
    parameter int GAP_CYCLES    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  col,
    input  logic [7:0]  line,
    output logic        busy,
    output logic        done,
    output logic [7:0]  bitmap,
    output logic [7:0]  attr,
    output logic [15:0] a,
    output logic        cs_n,
    output logic        oe_n,
    output logic        we_n,
    input  logic [7:0]  din
);

    typedef enum logic [2:0] {IDLE, BMP, GAP, ATT, END} state_t;

    localparam logic [3:0] AC_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] GC_LAST = 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  col_q, col_d;
    logic [7:0]  line_q, line_d;
    logic        strobe_d;
    logic [15:0] a_d;
    logic [7:0]  bitmap_d, attr_d;
    logic        done_d, busy_d;
    logic [15:0] bmp_addr, att_addr;
    logic        hit;

    assign we_n     = 1'b1;
    assign bmp_addr = {3'b010, line[7:6], line[2:0], line[5:3], col};
    assign att_addr = 16'h5800 + {6'b0, line_q[7:3], col_q};

`ifdef VRAM_FETCH_ATTR_CACHE_EN
    logic [15:0] cache_addr_q;
    logic        cache_vld_q;

    // a holds the attribute address throughout GAP, so compare against it
    assign hit = cache_vld_q && (cache_addr_q == a);

    // Remember the attribute address of every completed ATT access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_addr_q <= 16'h0000;
            cache_vld_q  <= 1'b0;
        end else if (state_q == ATT && cnt_q == AC_LAST) begin
            cache_addr_q <= a;
            cache_vld_q  <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // Next-state, counter and next-output values for the fetch sequence
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        line_d   = line_q;
        strobe_d = cs_n;
        a_d      = a;
        bitmap_d = bitmap;
        attr_d   = attr;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    col_d    = col;
                    line_d   = line;
                    a_d      = bmp_addr;
                    strobe_d = 1'b0;
                    cnt_d    = 4'd0;
                    state_d  = BMP;
                end
            end
            BMP: begin
                if (cnt_q == AC_LAST) begin
                    bitmap_d = din;
                    strobe_d = 1'b1;
                    a_d      = att_addr;
                    cnt_d    = 4'd0;
                    state_d  = GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (cnt_q == GC_LAST) begin
                    cnt_d = 4'd0;
                    if (hit) begin
                        state_d = END;
                        done_d  = (GC_LAST == 4'd0);
                    end else begin
                        strobe_d = 1'b0;
                        state_d  = ATT;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ATT: begin
                if (cnt_q == AC_LAST) begin
                    attr_d   = din;
                    strobe_d = 1'b1;
                    cnt_d    = 4'd0;
                    state_d  = END;
                    done_d   = (GC_LAST == 4'd0);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            END: begin
                if (cnt_q == GC_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    done_d = ((cnt_q + 4'd1) == GC_LAST);
                end
            end
            default: begin
                strobe_d = 1'b1;
                cnt_d    = 4'd0;
                state_d  = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register and registered bus/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            col_q   <= 5'd0;
            line_q  <= 8'd0;
            cs_n    <= 1'b1;
            oe_n    <= 1'b1;
            a       <= 16'h0000;
            bitmap  <= 8'h00;
            attr    <= 8'h00;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            line_q  <= line_d;
            cs_n    <= strobe_d;
            oe_n    <= strobe_d;
            a       <= a_d;
            bitmap  <= bitmap_d;
            attr    <= attr_d;
            done    <= done_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: doc/vram_fetcher.md
Name: vram_fetcher

Overview:
- Bus initiator for the VRAM port (bank 1) of the RAM controller. Drives the active-low cs_n/oe_n/we_n strobe protocol that the controller edge-detects.
- On each start request, fetches one character cell: the bitmap byte, then the attribute byte, for a given column and screen line.
- Sits between the video timing generator and the bank-1 port; we_n is held permanently high because it is read-only.

Parameters:
- ACCESS_CYCLES, 6: clocks each strobe is held low. The data byte is sampled on the last low cycle. Legal range 4..15; covers the controller's worst-case arbitration behind a bank-2 access.
- GAP_CYCLES, 1: clocks strobes are held high between accesses. Legal range 1..15; the controller needs at least 1 to see a new falling edge.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  fetch request; sampled only in IDLE
- col  in  5  character column 0..31; captured when start is accepted
- line  in  8  screen line 0..191; captured when start is accepted
- busy  out  1  high while a fetch is in progress (state != IDLE)
- done  out  1  one-cycle pulse; bitmap/attr valid from this cycle on
- bitmap  out  8  fetched bitmap byte; held until the next sample
- attr  out  8  fetched attribute byte; held until the next sample
- a  out  16  VRAM address to the controller
- cs_n  out  1  chip select, active low
- oe_n  out  1  output enable, active low
- we_n  out  1  write enable; constant 1
- din  in  8  read data from the controller's bank-1 data output

Behaviour:
- All outputs are registered.
- Reset values: cs_n=1, oe_n=1, we_n=1, a=0, busy=0, done=0, bitmap=0, attr=0, state=IDLE, counter=0.
- Reset is asynchronous: strobes return high immediately, even mid-access.
- Address arithmetic:
  - Bitmap address = {3'b010, line[7:6], line[2:0], line[5:3], col[4:0]}.
  - Attribute address = 16'h5800 + line[7:3]*32 + col.
- FSM states: IDLE, BMP, GAP, ATT, END.
  - IDLE: if start=1, capture col/line, load a=bitmap address, drive cs_n=oe_n=0 from the next cycle, go to BMP. Otherwise stay; strobes stay high.
  - BMP: strobes low for ACCESS_CYCLES clocks. On the last one, bitmap<=din. Go to GAP with strobes high.
  - GAP: strobes high for GAP_CYCLES clocks. a switches to the attribute address on entry to GAP, never while strobes are low. Then go to ATT.
  - ATT: strobes low for ACCESS_CYCLES clocks. On the last one, attr<=din. Go to END.
  - END: strobes high for GAP_CYCLES clocks. done=1 on the last END cycle. Then go to IDLE.
- cs_n and oe_n always change together. a is stable for the whole low phase.
- Timing with defaults: start accepted at cycle 0 → cs_n low cycles 1–6, high cycle 7, low cycles 8–13, high cycle 14 with done=1, busy=0 from cycle 15.
  - Generally, done arrives at cycle 2*ACCESS_CYCLES + 2*GAP_CYCLES.
- start while busy=1 is ignored and is not queued.
- start held high continuously gives back-to-back fetches. Each new fetch is accepted in the IDLE cycle after done. Strobes are therefore high for at least GAP_CYCLES+1 clocks between fetches.
- col/line changes while busy have no effect.
- Out-of-range line (>191) is not checked; the address formula is applied as-is.

Optional Feature:
- Macro: VRAM_FETCH_ATTR_CACHE_EN.
- When defined:
  - Hold a registered last-attribute address plus a valid bit (cleared by reset).
  - If the new attribute address equals the cached address and valid=1, skip ATT: GAP goes directly to END, attr keeps its cached value, and only one strobe low phase occurs.
  - Done then arrives at ACCESS_CYCLES + 2*GAP_CYCLES.
  - The cache is updated whenever ATT completes.
- When undefined: every fetch performs both accesses, with no cache logic.

Test Plan:
- col=0, line=0, din model returns 8'hAA then 8'h38 → a=16'h4000 then 16'h5800; bitmap=AA, attr=38; done pulses at cycle 14 with defaults.
- col=31, line=191 → bitmap address 16'h57FF, attribute address 16'h5AFF; strobes low exactly 6 cycles each, 1 high cycle between.
- col=3, line=65 → addresses 16'h4903 then 16'h5903. start pulses during busy produce no extra strobe edges.
- Assert rst_n=0 in the middle of the BMP phase → cs_n/oe_n high in the same cycle (asynchronous); bitmap=0, busy=0. After release, a new start gives a full fetch.
- start held at 1 for 3 fetches → 3 done pulses 15 cycles apart; cs_n high for ≥2 cycles between fetches; we_n constantly 1.
- With VRAM_FETCH_ATTR_CACHE_EN: line=0 then line=1 at col=5 → second fetch issues only address 16'h4105, attr reused, done at cycle 8.
